// File: rtl/srrc_tx_ctrl_pkg.sv
// tx_pkg: shared types and defaults for the SRRC transmit sequencer.
//   tx_state_e : frame FSM encoding (IDLE, RUN, FLUSH, DONE)
//   sym_t      : one I/Q symbol pair as driven into the two SRRC rails
//   SYM_*      : 2-bit symbol codes (+1, -1, zero-stuff)
package tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic [1:0] i;
    logic [1:0] q;
  } sym_t;

  localparam logic [1:0] SYM_P1   = 2'b01;
  localparam logic [1:0] SYM_M1   = 2'b11;
  localparam logic [1:0] SYM_ZERO = 2'b00;

  localparam int OSF_DEF       = 4;
  localparam int FLUSH_LEN_DEF = 32;
  localparam int SRRC_LAT_DEF  = 1;
  localparam int LEN_W_DEF     = 11;

endpackage

// File: rtl/srrc_tx_ctrl_vld_dly.sv
// srrc_vld_dly: 1-bit delay line of STAGES flops with sync reset.
// Tracks the SRRC filter latency so the sample strobe lines up with Dout.
//   clk, rst : clock, synchronous active-high reset
//   d        : strobe in (srrc_en)
//   q        : strobe delayed by STAGES cycles (out_valid)
module srrc_vld_dly #(
  parameter int STAGES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES:1] vld_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= d;
      for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  assign q = vld_pipe[STAGES];

endmodule

// File: rtl/srrc_tx_ctrl.sv
// srrc_tx_ctrl: frame sequencer for the QAM pulse-shaping stage.
// Accepts I/Q symbols on a valid/ready handshake, zero-stuffs each to OSF
// samples, drives en/Din of the I and Q SRRC rails, then flushes FLUSH_LEN
// zeros to drain the filter tail.
//   start/abort/frame_len : frame control (start sampled in IDLE only)
//   s_valid/s_i/s_q/s_ready : symbol stream in
//   srrc_en/srrc_din_i/q  : registered filter drive
//   out_valid             : srrc_en delayed by SRRC_LAT
//   busy/frame_done/underrun : frame status
module srrc_tx_ctrl
  import tx_pkg::*;
#(
  parameter int OSF       = OSF_DEF,
  parameter int FLUSH_LEN = FLUSH_LEN_DEF,
  parameter int SRRC_LAT  = SRRC_LAT_DEF,
  parameter int LEN_W     = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             s_valid,
  input  logic [1:0]       s_i,
  input  logic [1:0]       s_q,
  output logic             s_ready,
  output logic             srrc_en,
  output logic [1:0]       srrc_din_i,
  output logic [1:0]       srrc_din_q,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_done,
  output logic             underrun
);

  localparam int PH_W = (OSF > 1) ? $clog2(OSF) : 1;
  // flush counter also holds FLUSH_LEN for the drain cycle below
  localparam int FL_W = $clog2(FLUSH_LEN + 1);

  tx_state_e        state, state_n;
  logic [PH_W-1:0]  phase, phase_n;
  logic [LEN_W-1:0] sym_cnt, sym_cnt_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [FL_W-1:0]  flush_cnt, flush_cnt_n;
  logic             en_q, en_n;
  sym_t             din_q, din_n;
  logic             und_q, und_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase     <= '0;
      sym_cnt   <= '0;
      len_q     <= '0;
      flush_cnt <= '0;
      en_q      <= 1'b0;
      din_q     <= '0;
      und_q     <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      sym_cnt   <= sym_cnt_n;
      len_q     <= len_n;
      flush_cnt <= flush_cnt_n;
      en_q      <= en_n;
      din_q     <= din_n;
      und_q     <= und_n;
    end
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    sym_cnt_n   = sym_cnt;
    len_n       = len_q;
    flush_cnt_n = flush_cnt;
    en_n        = 1'b0;
    din_n       = '{i: SYM_ZERO, q: SYM_ZERO};
    und_n       = und_q;
    case (state)
      ST_IDLE: begin
        // abort is ignored here, so start+abort simply starts
        if (start) begin
          len_n       = frame_len;
          und_n       = 1'b0;
          phase_n     = '0;
          sym_cnt_n   = '0;
          flush_cnt_n = '0;
          state_n     = (frame_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (phase == '0) begin
          if (s_valid) begin
            en_n    = 1'b1;
            din_n   = '{i: s_i, q: s_q};
            phase_n = PH_W'(1);
          end else begin
            // stall: filter frozen, remember the missed symbol slot
            und_n = 1'b1;
          end
        end else begin
          en_n = 1'b1;
          if (phase == PH_W'(OSF - 1)) begin
            phase_n = '0;
            if (sym_cnt == len_q - 1'b1) begin
              state_n     = ST_FLUSH;
              flush_cnt_n = '0;
            end else begin
              sym_cnt_n = sym_cnt + 1'b1;
            end
          end else begin
            phase_n = phase + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (flush_cnt == FL_W'(FLUSH_LEN)) begin
          // drain cycle: the last zero is already on the registered drive,
          // so DONE lands on the first cycle with srrc_en low
          state_n = ST_DONE;
        end else begin
          en_n        = 1'b1;
          flush_cnt_n = flush_cnt + 1'b1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  srrc_vld_dly #(.STAGES(SRRC_LAT)) u_vld_dly (
    .clk (clk),
    .rst (rst),
    .d   (en_q),
    .q   (out_valid)
  );

  assign s_ready    = (state == ST_RUN) && (phase == '0);
  assign srrc_en    = en_q;
  assign srrc_din_i = din_q.i;
  assign srrc_din_q = din_q.q;
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);
  assign underrun   = und_q;

endmodule

// File: tb/tb_srrc_tx_ctrl.sv
module tb_srrc_tx_ctrl;
  localparam int OSF = 4;
  localparam int FL  = 32;
  localparam int LAT = 1;
  localparam int LW  = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, abort, s_valid;
  logic [LW-1:0] frame_len;
  logic [1:0]    s_i, s_q;
  logic          s_ready, srrc_en, out_valid, busy, frame_done, underrun;
  logic [1:0]    srrc_din_i, srrc_din_q;

  srrc_tx_ctrl #(.OSF(OSF), .FLUSH_LEN(FL), .SRRC_LAT(LAT), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_len(frame_len),
    .s_valid(s_valid), .s_i(s_i), .s_q(s_q), .s_ready(s_ready),
    .srrc_en(srrc_en), .srrc_din_i(srrc_din_i), .srrc_din_q(srrc_din_q),
    .out_valid(out_valid), .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );

  int errs = 0, checks = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // {ready, en, din_i, din_q, out_valid, busy, frame_done, underrun}
  function automatic logic [9:0] obs();
    return {s_ready, srrc_en, srrc_din_i, srrc_din_q, out_valid, busy, frame_done, underrun};
  endfunction

  function automatic logic [9:0] mk(logic r, logic e, logic [1:0] di, logic [1:0] dq,
                                    logic ov, logic b, logic d, logic u);
    return {r, e, di, dq, ov, b, d, u};
  endfunction

  typedef struct {
    logic          st, ab;
    logic [LW-1:0] len;
    logic          sv;
    logic [1:0]    si, sq;
    logic [9:0]    exp;
  } vec_t;
  vec_t tbl[10];

  logic [1:0] fi[4], fq[4];

  // per-frame results
  int r_nen, r_gaps, r_nov, r_ndone, r_done_ok, r_din_err, r_timeout, r_ov_align;
  logic r_u_start, r_u_pre;
  logic [9:0] r_snap;

  task automatic run_frame(input int len, input int stall_sym, input int stall_n,
                           input int abort_at, input int rst_at, input int bstart_at,
                           input int max_cyc);
    int idx = 0, stalls = 0, zrun = 0, tail = -1, c_first_en = -1, c_first_ov = -1;
    bit hs, was_busy = 0, prev_en = 0, fired_a = 0, fired_r = 0, fired_b = 0, snap_pend = 0;
    logic [1:0] ei, eq;
    r_nen = 0; r_gaps = 0; r_nov = 0; r_ndone = 0; r_done_ok = 0; r_din_err = 0;
    r_timeout = 1; r_snap = '1; r_u_pre = 1'b0; r_u_start = 1'b1;
    start = 1'b1; abort = 1'b0; frame_len = LW'(len);
    s_valid = (len > 0); s_i = fi[0]; s_q = fq[0];
    for (int c = 0; c < max_cyc; c++) begin
      hs = s_ready && s_valid;
      @(posedge clk);
      if (hs) idx++;
      @(negedge clk);
      start = 1'b0; abort = 1'b0; rst = 1'b0;
      if (c == 0) r_u_start = underrun;
      if (snap_pend) begin r_snap = obs(); snap_pend = 0; end
      if (srrc_en) begin
        if (r_nen < len * OSF && r_nen % OSF == 0) begin
          ei = fi[(r_nen / OSF) % 4]; eq = fq[(r_nen / OSF) % 4];
        end else begin
          ei = 2'b00; eq = 2'b00;
        end
        if (srrc_din_i != ei || srrc_din_q != eq) r_din_err++;
        if (c_first_en < 0) c_first_en = c; else r_gaps += zrun;
        zrun = 0;
        r_nen++;
      end else if (c_first_en >= 0) begin
        zrun++;
      end
      if (out_valid) begin
        r_nov++;
        if (c_first_ov < 0) c_first_ov = c;
      end
      if (frame_done) begin
        r_ndone++;
        if (prev_en && !srrc_en && busy) r_done_ok++;
      end
      prev_en = srrc_en;
      if (busy) was_busy = 1;
      if (tail > 0) begin
        tail--;
        if (tail == 0) begin r_timeout = 0; break; end
      end else if (tail < 0 && was_busy && !busy) begin
        tail = 2;
      end
      if (rst_at >= 0 && !fired_r && r_nen == rst_at) begin
        rst = 1'b1; r_u_pre = underrun; fired_r = 1; snap_pend = 1;
      end
      if (abort_at >= 0 && !fired_a && r_nen == abort_at) begin
        abort = 1'b1; fired_a = 1; snap_pend = 1;
      end
      if (bstart_at >= 0 && !fired_b && r_nen == bstart_at) begin
        start = 1'b1; frame_len = '0; fired_b = 1;
      end
      if (idx < len) begin
        if (idx == stall_sym && stalls < stall_n && s_ready) begin
          s_valid = 1'b0; stalls++;
        end else begin
          s_valid = 1'b1; s_i = fi[idx % 4]; s_q = fq[idx % 4];
        end
      end else begin
        s_valid = 1'b0; s_i = 2'b00; s_q = 2'b00;
      end
    end
    r_ov_align = (c_first_en >= 0 && c_first_ov == c_first_en + LAT) ? 1 : 0;
  endtask

  initial begin
    fi[0] = 2'b01; fi[1] = 2'b11; fi[2] = 2'b01; fi[3] = 2'b11;
    fq[0] = 2'b11; fq[1] = 2'b11; fq[2] = 2'b01; fq[3] = 2'b01;

    // zero-length frame, abort in IDLE, start+abort, abort in FLUSH
    tbl[0] = '{1, 0, 0, 0, 2'b00, 2'b00, mk(0, 0, 2'b00, 2'b00, 0, 1, 1, 0)};
    tbl[1] = '{0, 0, 0, 0, 2'b00, 2'b00, mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0)};
    tbl[2] = '{0, 1, 0, 0, 2'b00, 2'b00, mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0)};
    tbl[3] = '{1, 1, 1, 0, 2'b00, 2'b00, mk(1, 0, 2'b00, 2'b00, 0, 1, 0, 0)};
    tbl[4] = '{0, 0, 0, 1, 2'b01, 2'b11, mk(0, 1, 2'b01, 2'b11, 0, 1, 0, 0)};
    tbl[5] = '{0, 0, 0, 0, 2'b00, 2'b00, mk(0, 1, 2'b00, 2'b00, 1, 1, 0, 0)};
    tbl[6] = '{0, 0, 0, 0, 2'b00, 2'b00, mk(0, 1, 2'b00, 2'b00, 1, 1, 0, 0)};
    tbl[7] = '{0, 0, 0, 0, 2'b00, 2'b00, mk(0, 1, 2'b00, 2'b00, 1, 1, 0, 0)};
    tbl[8] = '{0, 1, 0, 0, 2'b00, 2'b00, mk(0, 0, 2'b00, 2'b00, 1, 0, 0, 0)};
    tbl[9] = '{0, 0, 0, 0, 2'b00, 2'b00, mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0)};

    rst = 1'b1; start = 1'b0; abort = 1'b0; frame_len = '0;
    s_valid = 1'b0; s_i = 2'b00; s_q = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'(obs()), 0);
    rst = 1'b0;

    for (int k = 0; k < 10; k++) begin
      start = tbl[k].st; abort = tbl[k].ab; frame_len = tbl[k].len;
      s_valid = tbl[k].sv; s_i = tbl[k].si; s_q = tbl[k].sq;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d", k), int'(obs()), int'(tbl[k].exp));
    end
    start = 1'b0; abort = 1'b0; s_valid = 1'b0;

    // normal frame, 3 symbols
    run_frame(3, -1, 0, -1, -1, -1, 200);
    chk("norm_timeout", r_timeout, 0);
    chk("norm_en_cycles", r_nen, 3 * OSF + FL);
    chk("norm_en_gaps", r_gaps, 0);
    chk("norm_din", r_din_err, 0);
    chk("norm_done_cnt", r_ndone, 1);
    chk("norm_done_after_en", r_done_ok, 1);
    chk("norm_ov_cycles", r_nov, 3 * OSF + FL);
    chk("norm_ov_align", r_ov_align, 1);
    chk("norm_underrun", int'(underrun), 0);

    // stall 5 slots before symbol index 1
    run_frame(2, 1, 5, -1, -1, -1, 200);
    chk("stall_timeout", r_timeout, 0);
    chk("stall_en_cycles", r_nen, 2 * OSF + FL);
    chk("stall_gap_cycles", r_gaps, 5);
    chk("stall_din", r_din_err, 0);
    chk("stall_underrun", int'(underrun), 1);
    chk("stall_ov_cycles", r_nov, 2 * OSF + FL);

    // abort in FLUSH at flush count 10 (4 symbol samples + 10 flush samples seen)
    run_frame(1, -1, 0, OSF + 10, -1, -1, 200);
    chk("abort_underrun_cleared", int'(r_u_start), 0);
    chk("abort_snap", int'(r_snap & 10'b11_1111_0110), 0);
    chk("abort_no_done", r_ndone, 0);
    chk("abort_en_cycles", r_nen, OSF + 10);

    // new frame after abort
    run_frame(1, -1, 0, -1, -1, -1, 200);
    chk("restart_en_cycles", r_nen, OSF + FL);
    chk("restart_done", r_ndone, 1);
    chk("restart_din", r_din_err, 0);

    // start with frame_len=0 while busy must not disturb the frame
    run_frame(2, -1, 0, -1, -1, 3, 200);
    chk("bstart_en_cycles", r_nen, 2 * OSF + FL);
    chk("bstart_done", r_ndone, 1);
    chk("bstart_din", r_din_err, 0);

    // reset at symbol 1, phase 2, after an initial stall set underrun
    run_frame(3, 0, 2, -1, OSF + 2, -1, 200);
    chk("rst_underrun_before", int'(r_u_pre), 1);
    chk("rst_snap", int'(r_snap), 0);
    chk("rst_timeout", r_timeout, 0);

    // longest frame: symbol counter must not wrap
    run_frame(2047, -1, 0, -1, -1, -1, 9000);
    chk("max_timeout", r_timeout, 0);
    chk("max_en_cycles", r_nen, 2047 * OSF + FL);
    chk("max_done", r_ndone, 1);
    chk("max_din", r_din_err, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/srrc_tx_ctrl.md
Name: srrc_tx_ctrl

Overview:
Frame sequencer for the QAM transmitter's pulse-shaping stage. Accepts 2-bit I/Q symbols over a valid/ready handshake and zero-stuffs them to OSF samples per symbol. Drives the enable and data inputs of the I-rail and Q-rail SRRC filter instances, then flushes the filter tail with zeros. Generates frame-level status and an output-valid strobe aligned to SRRC Dout.

Parameters:
OSF, 4, oversampling factor; samples per symbol (≥2).
FLUSH_LEN, 32, zero samples driven after the last symbol to drain the filter (≥1).
SRRC_LAT, 1, cycles from SRRC en/Din to corresponding Dout (≥1).
LEN_W, 11, width of the frame-length field in symbols.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  single-cycle frame start; sampled only in IDLE.
abort  in  1  cancel the current frame; sampled in RUN/FLUSH.
frame_len  in  LEN_W  symbols in the frame; latched on start.
s_valid  in  1  symbol available.
s_i  in  2  I symbol (2'b01 = +1, 2'b11 = -1).
s_q  in  2  Q symbol, same encoding.
s_ready  out  1  controller accepts a symbol this cycle.
srrc_en  out  1  enable to both SRRC instances.
srrc_din_i  out  2  Din to the I-rail SRRC.
srrc_din_q  out  2  Din to the Q-rail SRRC.
out_valid  out  1  SRRC Dout carries a frame sample this cycle.
busy  out  1  state ≠ IDLE.
frame_done  out  1  one-cycle pulse at frame completion.
underrun  out  1  sticky: s_valid was low when a symbol was due; cleared on start.

Behaviour:
- Reset (sync, priority over all inputs): state=IDLE, counters=0, outputs 0; srrc_din_i/q=2'b00; out_valid pipeline cleared.
- States:
  - IDLE: start=1 → latch frame_len, clear underrun, go to RUN. If frame_len=0, go directly to DONE instead.
  - RUN: phase counter 0..OSF-1 and symbol counter 0..len-1.
  - FLUSH: flush counter 0..FLUSH_LEN-1.
  - DONE: lasts one cycle, then IDLE.
- s_ready = (state==RUN && phase==0). It is combinational from registers only, with no path from s_valid.
- RUN, phase 0:
  - If s_valid: registered next cycle srrc_en=1, srrc_din_i/q = s_i/s_q, phase→1.
  - If !s_valid: srrc_en=0, din=00, phase held, underrun←1. This is a stall; filter state is frozen.
- RUN, phase 1..OSF-1: srrc_en=1, din=2'b00, phase increments and wraps to 0.
- RUN exit: on the wrap after symbol len-1, go to FLUSH.
- FLUSH: srrc_en=1, din=00 for exactly FLUSH_LEN cycles, then DONE.
- DONE: frame_done=1, srrc_en=0, busy still 1. Next cycle IDLE, busy=0.
- Sample count: a frame without stalls produces len*OSF + FLUSH_LEN consecutive srrc_en=1 cycles.
- Output timing:
  - srrc_en/din are registered; an accepted symbol appears on srrc_din one cycle after the handshake.
  - out_valid = srrc_en delayed by SRRC_LAT (shift register).
  - Stall cycles produce out_valid=0 gaps.
- abort in RUN/FLUSH: next cycle state=IDLE, srrc_en=0, din=00, no frame_done. The out_valid pipeline drains naturally. Abort has priority over a coincident phase/flush transition.
- start while busy: ignored.
- abort in IDLE: ignored.
- start and abort in the same IDLE cycle: start wins.
- Counter widths: the symbol counter is LEN_W bits. frame_len = 2^LEN_W − 1 must complete without wrap.

Decomposition:
- Shared package tx_pkg:
  - state encoding (IDLE, RUN, FLUSH, DONE);
  - symbol codes SYM_P1=2'b01, SYM_M1=2'b11, SYM_ZERO=2'b00;
  - default OSF/FLUSH_LEN.
- One sub-module: srrc_vld_dly, a parameterised 1-bit delay line of SRRC_LAT stages with sync reset, producing out_valid.
- FSM and counters live in srrc_tx_ctrl.

Test Plan:
- Normal frame: OSF=4, FLUSH_LEN=32, frame_len=3, s_valid held 1 with I=01,11,01 and Q=11,11,01.
  - srrc_din_i sequence: 01,00,00,00,11,00,00,00,01,00,00,00, then 32×00, all with srrc_en=1 (44 cycles).
  - frame_done pulses 1 cycle later; out_valid high 44 cycles, shifted by SRRC_LAT.
- Stall: frame_len=2, s_valid low for 5 cycles before symbol 2.
  - srrc_en=0 for exactly 5 cycles and underrun=1.
  - Total srrc_en=1 cycles = 40; underrun clears on the next start.
- Zero-length frame: frame_len=0, start → DONE next cycle; frame_done pulses with no srrc_en cycles and s_ready never asserted.
- Abort in FLUSH at flush count 10: next cycle srrc_en=0, busy=0, no frame_done. A start 1 cycle later begins a new frame normally.
- Reset mid-RUN: assert rst at symbol 1, phase 2. The next edge leaves all outputs 0, state IDLE, underrun=0, and out_valid low after that edge.
- start during busy and start+abort in IDLE: a busy start is ignored with the counters undisturbed; start+abort in IDLE enters RUN.
